// File: rtl/stub_rf_datagen_mc.sv
// Multi-channel complex TX stimulus generator: ramp, constant, PRBS or square
// patterns on NUM_CH I/Q streams. A periodic valid strobe is used, and the
// generator supports back-pressure via I_tReady and optional finite bursts.
module stub_rf_datagen_mc #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned EN_PERIOD = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     I_clk,
    input  logic                     I_rst_n,
    input  logic                     I_enable,
    input  logic                     I_tReady,
    input  logic [1:0]               I_mode,
    input  logic [DATA_W-1:0]        I_constVal,
    input  logic [CNT_W-1:0]         I_burstLen,
    output logic                     O_txEn,
    output logic [NUM_CH*DATA_W-1:0] O_txIm,
    output logic [NUM_CH*DATA_W-1:0] O_txRe,
    output logic [CNT_W-1:0]         O_sampleCnt,
    output logic                     O_busy,
    output logic                     O_done
);

    localparam int unsigned PH_W   = $clog2(EN_PERIOD);
    localparam int unsigned LFSR_W = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [PH_W-1:0] PH_ARM  = PH_W'(EN_PERIOD - 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(EN_PERIOD - 1);

    localparam logic [DATA_W-1:0] SQ_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SQ_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]                          state_q, state_nxt;
    logic [PH_W-1:0]                     ph_q, ph_nxt;
    logic                                txen_q, txen_nxt;
    logic [NUM_CH-1:0][DATA_W-1:0]       im_q, im_nxt;
    logic [NUM_CH-1:0][DATA_W-1:0]       re_q, re_nxt;
    logic [NUM_CH-1:0][LFSR_W-1:0]       lfsr_q, lfsr_nxt;
    logic [CNT_W-1:0]                    cnt_q, cnt_nxt, cnt_inc;
    logic                                busy_q, busy_nxt;
    logic                                done_q, done_nxt;
    logic [1:0]                          mode_q, mode_nxt;
    logic [DATA_W-1:0]                   const_q, const_nxt;
    logic [CNT_W-1:0]                    burst_q, burst_nxt;
    logic                                xfer;
    logic [LFSR_W-1:0]                   lfsr_step;

    // Per-channel seed keeps the channels decorrelated
    function automatic logic [LFSR_W-1:0] seed_f(input int unsigned k);
        return 15'h7FFF ^ LFSR_W'(k);
    endfunction

    // Fibonacci LFSR x^15 + x^14 + 1
    function automatic logic [LFSR_W-1:0] step_f(input logic [LFSR_W-1:0] l);
        return {l[13:0], l[14] ^ l[13]};
    endfunction

    // Next-state, strobe timing and pattern update
    always_comb begin
        state_nxt = state_q;
        ph_nxt    = ph_q;
        txen_nxt  = txen_q;
        im_nxt    = im_q;
        re_nxt    = re_q;
        lfsr_nxt  = lfsr_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = busy_q;
        done_nxt  = done_q;
        mode_nxt  = mode_q;
        const_nxt = const_q;
        burst_nxt = burst_q;
        lfsr_step = '0;
        xfer      = txen_q && I_tReady;
        cnt_inc   = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (I_enable) begin
                    state_nxt = ST_RUN;
                    busy_nxt  = 1'b1;
                    mode_nxt  = I_mode;
                    const_nxt = I_constVal;
                    burst_nxt = I_burstLen;
                    // Preload the first sample so data is valid at the first strobe
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        case (I_mode)
                            2'd0: begin
                                im_nxt[k] = '0;
                                re_nxt[k] = '0;
                            end
                            2'd1: begin
                                im_nxt[k] = I_constVal;
                                re_nxt[k] = I_constVal;
                            end
                            2'd2: begin
                                im_nxt[k] = lfsr_q[k][DATA_W-1:0];
                                re_nxt[k] = ~lfsr_q[k][DATA_W-1:0];
                            end
                            default: begin
                                im_nxt[k] = SQ_MAX;
                                re_nxt[k] = SQ_MIN;
                            end
                        endcase
                    end
                end
            end

            ST_RUN: begin
                // Phase freezes while a strobe is stalled by the sink
                if (!(txen_q && !I_tReady)) begin
                    ph_nxt = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
                end
                if (ph_q == PH_ARM) begin
                    txen_nxt = 1'b1;
                end
                if (xfer) begin
                    txen_nxt = 1'b0;
                    cnt_nxt  = cnt_inc;
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        lfsr_step   = step_f(lfsr_q[k]);
                        lfsr_nxt[k] = lfsr_step;
                        case (mode_q)
                            2'd0: begin
                                im_nxt[k] = im_q[k] + DATA_W'(2 * k + 1);
                                re_nxt[k] = re_q[k] + DATA_W'(2 * k + 2);
                            end
                            2'd1: begin
                                im_nxt[k] = im_q[k];
                                re_nxt[k] = re_q[k];
                            end
                            2'd2: begin
                                im_nxt[k] = lfsr_step[DATA_W-1:0];
                                re_nxt[k] = ~lfsr_step[DATA_W-1:0];
                            end
                            default: begin
                                im_nxt[k] = re_q[k];
                                re_nxt[k] = im_q[k];
                            end
                        endcase
                    end
                    if ((burst_q != '0) && (cnt_inc == burst_q)) begin
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                // DONE: everything frozen until enable drops
            end
        endcase

        // Dropping enable returns to IDLE from any state and wins over a transfer
        if (!I_enable) begin
            state_nxt = ST_IDLE;
            ph_nxt    = '0;
            txen_nxt  = 1'b0;
            im_nxt    = '0;
            re_nxt    = '0;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                lfsr_nxt[k] = seed_f(k);
            end
        end
    end

    // State and output registers
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            txen_q  <= 1'b0;
            im_q    <= '0;
            re_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            const_q <= '0;
            burst_q <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                lfsr_q[k] <= seed_f(k);
            end
        end else begin
            state_q <= state_nxt;
            ph_q    <= ph_nxt;
            txen_q  <= txen_nxt;
            im_q    <= im_nxt;
            re_q    <= re_nxt;
            lfsr_q  <= lfsr_nxt;
            cnt_q   <= cnt_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            mode_q  <= mode_nxt;
            const_q <= const_nxt;
            burst_q <= burst_nxt;
        end
    end

    assign O_txEn      = txen_q;
    assign O_txIm      = im_q;
    assign O_txRe      = re_q;
    assign O_sampleCnt = cnt_q;
    assign O_busy      = busy_q;
    assign O_done      = done_q;

endmodule

// File: tb/tb_stub_rf_datagen_mc.sv
// Directed bench for stub_rf_datagen_mc with default parameters.
module tb_stub_rf_datagen_mc;

    localparam int unsigned DW = 12;
    localparam int unsigned NC = 2;
    localparam int unsigned CW = 16;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              t_ready;
    logic [1:0]        mode;
    logic [DW-1:0]     const_val;
    logic [CW-1:0]     burst_len;
    logic              tx_en;
    logic [NC*DW-1:0]  tx_im;
    logic [NC*DW-1:0]  tx_re;
    logic [CW-1:0]     sample_cnt;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    stub_rf_datagen_mc #(
        .DATA_W(DW), .NUM_CH(NC), .EN_PERIOD(4), .CNT_W(CW)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_enable(enable), .I_tReady(t_ready),
        .I_mode(mode), .I_constVal(const_val), .I_burstLen(burst_len),
        .O_txEn(tx_en), .O_txIm(tx_im), .O_txRe(tx_re),
        .O_sampleCnt(sample_cnt), .O_busy(busy), .O_done(done)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] im_of(input int k);
        return tx_im[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] re_of(input int k);
        return tx_re[k*DW +: DW];
    endfunction

    // Bounded wait for the next valid strobe, sampled on the falling edge
    task automatic wait_strobe();
        int n = 0;
        while (!tx_en && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", 32'(tx_en), 32'd1);
    endtask

    // Drop enable for one edge and confirm the block is back at its cleared state
    task automatic go_idle(input string tag);
        enable = 1'b0;
        @(negedge clk);
        check({tag, "_idle_en"},  32'(tx_en), 32'd0);
        check({tag, "_idle_im"},  32'(tx_im), 32'd0);
        check({tag, "_idle_cnt"}, 32'(sample_cnt), 32'd0);
    endtask

    initial begin
        logic [14:0]   m0, m1;
        logic [DW-1:0] e;
        logic [DW-1:0] sq [3];
        int s;

        rst_n = 1'b0; enable = 1'b0; t_ready = 1'b1;
        mode = 2'd0; const_val = '0; burst_len = '0;
        repeat (3) @(negedge clk);
        check("rst_en",   32'(tx_en), 32'd0);
        check("rst_im",   32'(tx_im), 32'd0);
        check("rst_re",   32'(tx_re), 32'd0);
        check("rst_cnt",  32'(sample_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp, continuous: latency and period
        enable = 1'b1;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        check("start_en",   32'(tx_en), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("first_latency", 32'(tx_en), 32'(i == 3));
        end
        check("ramp0_im0", 32'(im_of(0)), 32'd0);
        check("ramp0_re1", 32'(re_of(1)), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("period", 32'(tx_en), 32'(i == 4));
        end
        for (int n = 1; n <= 1024; n++) begin
            wait_strobe();
            if (n < 4 || n == 1024) begin
                check("ramp_im0", 32'(im_of(0)), 32'((1 * n) % 4096));
                check("ramp_re0", 32'(re_of(0)), 32'((2 * n) % 4096));
                check("ramp_im1", 32'(im_of(1)), 32'((3 * n) % 4096));
                check("ramp_re1", 32'(re_of(1)), 32'((4 * n) % 4096));
                check("ramp_cnt", 32'(sample_cnt), 32'(n));
            end
            @(negedge clk);
        end

        // Stall for 5 cycles at strobe 1025
        wait_strobe();
        check("stall_pre_im0", 32'(im_of(0)), 32'h401);
        t_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_en",  32'(tx_en), 32'd1);
            check("stall_im0", 32'(im_of(0)), 32'h401);
            check("stall_re1", 32'(re_of(1)), 32'h004);
        end
        t_ready = 1'b1;
        @(negedge clk);
        check("stall_xfer_en",  32'(tx_en), 32'd0);
        check("stall_xfer_im0", 32'(im_of(0)), 32'h402);
        check("stall_xfer_cnt", 32'(sample_cnt), 32'd1026);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("stall_next", 32'(tx_en), 32'(i == 3));
        end
        // Enable drops while a transfer is pending: clear wins
        go_idle("ramp");

        // Constant burst of 3; later constVal change must be ignored
        mode = 2'd1; const_val = 12'h123; burst_len = 16'd3; enable = 1'b1;
        @(negedge clk);
        const_val = 12'h456;
        for (int n = 0; n < 3; n++) begin
            wait_strobe();
            check("const_im0", 32'(im_of(0)), 32'h123);
            check("const_re0", 32'(re_of(0)), 32'h123);
            check("const_im1", 32'(im_of(1)), 32'h123);
            check("const_re1", 32'(re_of(1)), 32'h123);
            @(negedge clk);
        end
        check("burst_done", 32'(done), 32'd1);
        check("burst_busy", 32'(busy), 32'd0);
        check("burst_cnt",  32'(sample_cnt), 32'd3);
        s = 0;
        repeat (12) begin
            @(negedge clk);
            s += int'(tx_en);
        end
        check("done_no_strobe", 32'(s), 32'd0);
        check("done_cnt_frozen", 32'(sample_cnt), 32'd3);
        go_idle("const");
        check("const_idle_done", 32'(done), 32'd0);
        check("const_idle_re",   32'(tx_re), 32'd0);

        // Burst of 1
        mode = 2'd0; burst_len = 16'd1; enable = 1'b1;
        wait_strobe();
        @(negedge clk);
        check("burst1_done", 32'(done), 32'd1);
        check("burst1_cnt",  32'(sample_cnt), 32'd1);
        go_idle("burst1");

        // PRBS against a reference LFSR
        mode = 2'd2; burst_len = '0; enable = 1'b1;
        m0 = 15'h7FFF; m1 = 15'h7FFE;
        for (int n = 0; n < 100; n++) begin
            wait_strobe();
            if (n == 0) begin
                check("prbs_first_im0", 32'(im_of(0)), 32'hFFF);
                check("prbs_first_re0", 32'(re_of(0)), 32'h000);
            end
            e = m0[DW-1:0];
            check("prbs_im0", 32'(im_of(0)), 32'(e));
            e = ~m0[DW-1:0];
            check("prbs_re0", 32'(re_of(0)), 32'(e));
            e = m1[DW-1:0];
            check("prbs_im1", 32'(im_of(1)), 32'(e));
            e = ~m1[DW-1:0];
            check("prbs_re1", 32'(re_of(1)), 32'(e));
            m0 = {m0[13:0], m0[14] ^ m0[13]};
            m1 = {m1[13:0], m1[14] ^ m1[13]};
            @(negedge clk);
        end
        go_idle("prbs");

        // Full-scale square
        mode = 2'd3; enable = 1'b1;
        sq[0] = 12'h7FF; sq[1] = 12'h800; sq[2] = 12'h7FF;
        for (int n = 0; n < 3; n++) begin
            wait_strobe();
            e = ~sq[n];
            check("sq_im0", 32'(im_of(0)), 32'(sq[n]));
            check("sq_re0", 32'(re_of(0)), 32'(e));
            check("sq_im1", 32'(im_of(1)), 32'(sq[n]));
            @(negedge clk);
        end
        go_idle("sq");

        // Asynchronous reset mid-burst, between clock edges
        mode = 2'd0; burst_len = 16'd10; enable = 1'b1;
        wait_strobe();
        @(negedge clk);
        wait_strobe();
        check("pre_rst_im0", 32'(im_of(0)), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_en",   32'(tx_en), 32'd0);
        check("async_im",   32'(tx_im), 32'd0);
        check("async_re",   32'(tx_re), 32'd0);
        check("async_cnt",  32'(sample_cnt), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; burst_len = '0;
        wait_strobe();
        check("restart_im0", 32'(im_of(0)), 32'd0);
        check("restart_cnt", 32'(sample_cnt), 32'd0);
        @(negedge clk);
        wait_strobe();
        check("restart_im0_1", 32'(im_of(0)), 32'd1);
        check("restart_re1_1", 32'(re_of(1)), 32'd4);
        check("restart_cnt_1", 32'(sample_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
